// File: rtl/gf_pkg.sv
`default_nettype none
// ============================================================================
// gf_pkg : shared width, counter width and FSM encoding for the GF(p) multiplier
// Revision: 1.0
// ============================================================================
package gf_pkg;

    localparam int GF_W     = 256;
    localparam int GF_CNT_W = $clog2(GF_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_t;

endpackage
`default_nettype wire

// File: rtl/gf_dbl_add_step.sv
`default_nettype none
// ============================================================================
// gf_dbl_add_step : one MSB-first interleaved step, R' = (2R + bit*A) mod P
// Revision: 1.0
// ============================================================================
module gf_dbl_add_step #(
    parameter int W = 256
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] a,
    input  logic [W-1:0] p,
    input  logic         bit_in,
    output logic [W-1:0] r_next
);

    logic [W:0]   dbl;
    logic [W:0]   red1;
    logic [W:0]   sum;
    logic [W+1:0] diff1;
    logic [W+1:0] diff2;
    logic         unused_msb;

    // The extra top bit of each difference is the borrow that picks the reduced value.
    assign dbl   = {r, 1'b0};
    assign diff1 = {1'b0, dbl} - {2'b00, p};
    assign red1  = diff1[W+1] ? dbl : diff1[W:0];

    assign sum   = bit_in ? (red1 + {1'b0, a}) : red1;
    assign diff2 = {1'b0, sum} - {2'b00, p};

    assign r_next     = diff2[W+1] ? sum[W-1:0] : diff2[W-1:0];
    assign unused_msb = diff2[W] ^ sum[W];

endmodule
`default_nettype wire

// File: rtl/gf_mul_serial.sv
`default_nettype none
// ============================================================================
// gf_mul_serial : bit-serial interleaved modular multiplier, GF_prod = GF_a*GF_b mod p
// Optional operand range check enabled by defining GF_MUL_OPCHECK_EN.
// Revision: 1.0
// ============================================================================
module gf_mul_serial
    import gf_pkg::*;
#(
    parameter int W = GF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] GF_a,
    input  logic [W-1:0] GF_b,
    input  logic [W-1:0] p,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] GF_prod,
    output logic         err
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    gf_state_t      state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   p_q;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_nxt;
    logic [CNT_W-1:0] cnt;

    gf_dbl_add_step #(.W(W)) u_step (
        .r      (r_q),
        .a      (a_q),
        .p      (p_q),
        .bit_in (b_q[cnt]),
        .r_next (r_nxt)
    );

`ifdef GF_MUL_OPCHECK_EN
    logic bad_ops;
    logic err_q;
    assign bad_ops = (GF_a >= p) || (GF_b >= p);
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            GF_prod <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            r_q     <= '0;
            cnt     <= '0;
`ifdef GF_MUL_OPCHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= GF_a;
                        b_q   <= GF_b;
                        p_q   <= p;
                        r_q   <= '0;
                        cnt   <= CNT_W'(W - 1);
                        ready <= 1'b0;
`ifdef GF_MUL_OPCHECK_EN
                        err_q <= bad_ops;
                        // Out-of-range operands bypass the bit loop entirely.
                        if (bad_ops) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            GF_prod <= '0;
                        end else begin
                            state   <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    r_q <= r_nxt;
                    if (cnt == '0) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        GF_prod <= r_nxt;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf_mul_serial.sv
`default_nettype none
// ============================================================================
// tb_gf_mul_serial : self-checking bench against a wide-arithmetic (a*b) % p model
// Revision: 1.0
// ============================================================================
module tb_gf_mul_serial;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] GF_a;
    logic [W-1:0] GF_b;
    logic [W-1:0] p;
    logic         ready;
    logic         done;
    logic [W-1:0] GF_prod;
    logic         err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gf_mul_serial #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .GF_a    (GF_a),
        .GF_b    (GF_b),
        .p       (p),
        .ready   (ready),
        .done    (done),
        .GF_prod (GF_prod),
        .err     (err)
    );

    function automatic logic [W-1:0] ref_mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] m);
        logic [2*W-1:0] full;
        full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        full = full % {{W{1'b0}}, m};
        return full[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_mod();
        logic [W-1:0] v;
        v = rand_w() >> $urandom_range(0, 250);
        v[0] = 1'b1;
        if (v < 3) v = 3;
        return v;
    endfunction

    function automatic logic [W-1:0] p25519();
        return (256'd1 << 255) - 256'd19;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation; lat counts edges after the accepting edge until done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                          output logic [W-1:0] prod, output int lat, output bit timeout);
        int waitc;
        waitc = 0;
        while (ready !== 1'b1 && waitc < W + 10) begin
            tick();
            waitc++;
        end
        GF_a  = a;
        GF_b  = b;
        p     = m;
        start = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 0;
        timeout = 1'b0;
        while (done !== 1'b1) begin
            if (lat > W + 4) begin
                timeout = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        prod = GF_prod;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        GF_a  = '0;
        GF_b  = '0;
        p     = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++;
        if (GF_prod !== '0) begin errors++; $display("FAIL reset_prod: got %0h expected 0", GF_prod); end
    endtask

    task automatic test_vectors();
        logic [W-1:0] ta[5], tb[5], tm[5], te[5];
        logic [W-1:0] prod;
        int lat;
        bit to;
        ta[0] = 256'd5;            tb[0] = 256'd7;            tm[0] = 256'd23;    te[0] = 256'd12;
        ta[1] = 256'd1 << 254;     tb[1] = 256'd2;            tm[1] = p25519();   te[1] = 256'd19;
        ta[2] = p25519() - 1;      tb[2] = p25519() - 1;      tm[2] = p25519();   te[2] = 256'd1;
        ta[3] = '0;                tb[3] = rand_w() % p25519(); tm[3] = p25519(); te[3] = '0;
        ta[4] = 256'd17;           tb[4] = '0;                tm[4] = 256'd23;    te[4] = '0;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tm[i], prod, lat, to);
            checks++;
            if (to || lat != W) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d (timeout=%0d) expected %0d", i, lat, to, W);
            end
            checks++;
            if (prod !== te[i]) begin
                errors++;
                $display("FAIL vec%0d_prod: got %0h expected %0h", i, prod, te[i]);
            end
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL vec%0d_err: got %b expected 0", i, err); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, m, prod, exp_v;
        int lat;
        bit to;
        for (int i = 0; i < 16; i++) begin
            m = (i % 4 == 0) ? p25519() : rand_mod();
            a = rand_w() % m;
            b = rand_w() % m;
            exp_v = ref_mulmod(a, b, m);
            run_op(a, b, m, prod, lat, to);
            checks++;
            if (to || lat != W || prod !== exp_v) begin
                errors++;
                $display("FAIL rand%0d_prod: got %0h lat=%0d expected %0h lat=%0d", i, prod, lat, exp_v, W);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, ready_bad, extra_done;
        int waitc;
        waitc = 0;
        while (ready !== 1'b1 && waitc < W + 10) begin tick(); waitc++; end
        GF_a  = 256'd5;
        GF_b  = 256'd7;
        p     = 256'd23;
        start = 1'b1;
        tick();
        start     = 1'b0;
        lat       = 0;
        ready_bad = 0;
        while (done !== 1'b1 && lat <= W + 4) begin
            if (ready !== 1'b0) ready_bad++;
            tick();
            lat++;
            if (lat == 99) begin
                GF_a  = 256'd9;
                GF_b  = 256'd11;
                p     = 256'd29;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (lat != W) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, W); end
        checks++;
        if (GF_prod !== 256'd12) begin errors++; $display("FAIL ignore_prod: got %0h expected c", GF_prod); end
        checks++;
        if (ready_bad != 0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL ignore_ready_busy: got %0d high cycles expected 0", ready_bad);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_return_idle: got ready=%b done=%b expected ready=1 done=0", ready, done);
        end
        extra_done = 0;
        repeat (W + 4) begin
            tick();
            if (done === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done != 0) begin errors++; $display("FAIL ignore_no_queue: got %0d done pulses expected 0", extra_done); end
    endtask

    task automatic test_rst_midrun();
        logic [W-1:0] a, b, prod;
        int lat, stray;
        bit to;
        GF_a  = rand_w() % p25519();
        GF_b  = rand_w() % p25519();
        p     = p25519();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (128) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || GF_prod !== '0) begin
            errors++;
            $display("FAIL rst_midrun: got ready=%b done=%b prod=%0h expected ready=1 done=0 prod=0",
                     ready, done, GF_prod);
        end
        stray = 0;
        repeat (W + 4) begin
            tick();
            if (done === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", stray); end
        a = rand_w() % p25519();
        b = rand_w() % p25519();
        run_op(a, b, p25519(), prod, lat, to);
        checks++;
        if (to || prod !== ref_mulmod(a, b, p25519())) begin
            errors++;
            $display("FAIL rst_fresh_op: got %0h expected %0h", prod, ref_mulmod(a, b, p25519()));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, m1, a2, b2, m2, prod1;
        int lat, gap, waitc;
        m1 = rand_mod();
        a1 = rand_w() % m1;
        b1 = rand_w() % m1;
        m2 = rand_mod();
        a2 = rand_w() % m2;
        b2 = rand_w() % m2;
        waitc = 0;
        while (ready !== 1'b1 && waitc < W + 10) begin tick(); waitc++; end
        GF_a  = a1;
        GF_b  = b1;
        p     = m1;
        start = 1'b1;
        tick();
        lat = 0;
        while (done !== 1'b1 && lat <= W + 4) begin tick(); lat++; end
        prod1 = GF_prod;
        GF_a  = a2;
        GF_b  = b2;
        p     = m2;
        gap   = 0;
        tick();
        gap++;
        while (done !== 1'b1 && gap <= W + 8) begin tick(); gap++; end
        start = 1'b0;
        checks++;
        if (lat != W || prod1 !== ref_mulmod(a1, b1, m1)) begin
            errors++;
            $display("FAIL b2b_first: got %0h lat=%0d expected %0h lat=%0d", prod1, lat, ref_mulmod(a1, b1, m1), W);
        end
        checks++;
        if (gap != W + 2) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", gap, W + 2); end
        checks++;
        if (GF_prod !== ref_mulmod(a2, b2, m2)) begin
            errors++;
            $display("FAIL b2b_second: got %0h expected %0h", GF_prod, ref_mulmod(a2, b2, m2));
        end
        tick();
        tick();
    endtask

`ifdef GF_MUL_OPCHECK_EN
    task automatic test_opcheck();
        logic [W-1:0] prod, a, b;
        int lat;
        bit to;
        run_op(256'd23, 256'd5, 256'd23, prod, lat, to);
        checks++;
        if (to || lat > 1 || err !== 1'b1 || prod !== '0) begin
            errors++;
            $display("FAIL opcheck_bad: got lat=%0d err=%b prod=%0h expected lat<=1 err=1 prod=0", lat, err, prod);
        end
        a = rand_w() % p25519();
        b = rand_w() % p25519();
        run_op(a, b, p25519(), prod, lat, to);
        checks++;
        if (to || err !== 1'b0 || prod !== ref_mulmod(a, b, p25519())) begin
            errors++;
            $display("FAIL opcheck_good: got err=%b prod=%0h expected err=0 prod=%0h", err, prod,
                     ref_mulmod(a, b, p25519()));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_rst_midrun();
        test_random();
        test_back_to_back();
`ifdef GF_MUL_OPCHECK_EN
        test_opcheck();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
